hazard_scoreboard: RTL and testbench

//  Consumer side of the decode stage's source/destination outputs. Tracks the

---
 rtl/hazard_scoreboard.sv | 84 ++++++++
 tb/tb_hazard_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for the ID stage: tracks EX/MEM destinations, drives
// freeze/bubble/global_stall and keeps a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter bit          FORWARDING = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           id_src1,
  input  logic [3:0]           id_src2,
  input  logic                 id_has_src1,
  input  logic                 id_has_src2,
  input  logic [3:0]           id_dst,
  input  logic                 id_wb_en,
  input  logic                 id_mem_read,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  input  logic                 stall_count_clr,
  output logic                 freeze,
  output logic                 bubble,
  output logic                 global_stall,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef struct packed {
    logic       v;
    logic [3:0] dst;
    logic       ld;
  } slot_t;

  slot_t ex_slot;
  slot_t mem_slot;
  logic  hit_ex;
  logic  hit_mem;
  logic  raw;

  always_comb begin
    hit_ex  = ex_slot.v  & ((id_has_src1 & (id_src1 == ex_slot.dst)) |
                            (id_has_src2 & (id_src2 == ex_slot.dst)));
    hit_mem = mem_slot.v & ((id_has_src1 & (id_src1 == mem_slot.dst)) |
                            (id_has_src2 & (id_src2 == mem_slot.dst)));
    // With forwarding only a load in EX cannot be bypassed in time.
    raw = FORWARDING ? (hit_ex & ex_slot.ld) : (hit_ex | hit_mem);
  end

  always_comb begin
    freeze       = 1'b0;
    bubble       = 1'b0;
    global_stall = 1'b0;
    if (rst) begin
      if (!mem_ready) begin
        global_stall = 1'b1;
        freeze       = 1'b1;
      end else if (branch_taken) begin
        bubble = 1'b1;
      end else if (raw) begin
        freeze = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_slot     <= '0;
      mem_slot    <= '0;
      stall_count <= '0;
    end else begin
      if (stall_count_clr)
        stall_count <= '0;
      else if (freeze && (stall_count != '1))
        stall_count <= stall_count + CNT_WIDTH'(1);

      if (mem_ready) begin
        mem_slot <= ex_slot;
        if (bubble)
          ex_slot <= '0;
        else
          ex_slot <= '{v: id_wb_en, dst: id_dst, ld: id_mem_read & id_wb_en};
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (no forwarding,
// forwarding, 2-bit counter) share one stimulus stream.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, id_dst;
  logic       id_has_src1, id_has_src2, id_wb_en, id_mem_read;
  logic       branch_taken, mem_ready, stall_count_clr;

  logic        f0, b0, g0;
  logic [15:0] c0;
  logic        f1, b1, g1;
  logic [15:0] c1;
  logic        f2, b2, g2;
  logic [1:0]  c2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FORWARDING(1'b0), .CNT_WIDTH(16)) d0 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_has_src1(id_has_src1), .id_has_src2(id_has_src2), .id_dst(id_dst),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .stall_count_clr(stall_count_clr),
    .freeze(f0), .bubble(b0), .global_stall(g0), .stall_count(c0));

  hazard_scoreboard #(.FORWARDING(1'b1), .CNT_WIDTH(16)) d1 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_has_src1(id_has_src1), .id_has_src2(id_has_src2), .id_dst(id_dst),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .stall_count_clr(stall_count_clr),
    .freeze(f1), .bubble(b1), .global_stall(g1), .stall_count(c1));

  hazard_scoreboard #(.FORWARDING(1'b1), .CNT_WIDTH(2)) d2 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_has_src1(id_has_src1), .id_has_src2(id_has_src2), .id_dst(id_dst),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .stall_count_clr(stall_count_clr),
    .freeze(f2), .bubble(b2), .global_stall(g2), .stall_count(c2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [3:0] s1, input logic h1, input logic [3:0] s2,
                        input logic h2, input logic [3:0] d, input logic wb,
                        input logic ld);
    id_src1 = s1; id_has_src1 = h1; id_src2 = s2; id_has_src2 = h2;
    id_dst = d; id_wb_en = wb; id_mem_read = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b1; stall_count_clr = 1'b0;
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    branch_taken = 1'b0; stall_count_clr = 1'b0; mem_ready = 1'b0;
    // T1: reset forces outputs low even with stall and hazard inputs present
    set_id(4'd1, 1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 1'b1);
    #3;
    check("t1_freeze", 32'(f0), 32'd0);
    check("t1_bubble", 32'(b0), 32'd0);
    check("t1_gstall", 32'(g0), 32'd0);
    check("t1_count",  32'(c0), 32'd0);

    // T2: no forwarding, dependent ADD stalls two cycles; forwarding: none
    do_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    check("t2_c0_freeze", 32'(f0), 32'd0);
    tick();
    set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    check("t2_c1_freeze", 32'(f0), 32'd1);
    check("t2_c1_bubble", 32'(b0), 32'd1);
    check("t2_fwd_c1_freeze", 32'(f1), 32'd0);
    tick();
    check("t2_c2_freeze", 32'(f0), 32'd1);
    check("t2_c2_bubble", 32'(b0), 32'd1);
    tick();
    check("t2_c3_freeze", 32'(f0), 32'd0);
    check("t2_c3_bubble", 32'(b0), 32'd0);
    check("t2_count", 32'(c0), 32'd2);
    check("t2_fwd_count", 32'(c1), 32'd0);

    // T3: forwarding, load-use stalls exactly one cycle
    do_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    tick();
    set_id(4'd0, 1'b0, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0);
    check("t3_c1_freeze", 32'(f1), 32'd1);
    check("t3_c1_bubble", 32'(b1), 32'd1);
    tick();
    check("t3_c2_freeze", 32'(f1), 32'd0);
    check("t3_count", 32'(c1), 32'd1);

    // T4: index match without has_src is not a hazard
    do_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
    tick();
    set_id(4'd5, 1'b0, 4'd5, 1'b0, 4'd6, 1'b0, 1'b0);
    check("t4_nofwd_freeze", 32'(f0), 32'd0);
    check("t4_fwd_freeze", 32'(f1), 32'd0);
    check("t4_bubble", 32'(b0), 32'd0);
    tick();
    check("t4_count", 32'(c0), 32'd0);

    // T5: memory stall over a pending hazard, then normal resolution
    do_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    tick();
    set_id(4'd6, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t5_gs_freeze", 32'(f0), 32'd1);
      check("t5_gs_bubble", 32'(b0), 32'd0);
      check("t5_gs_flag",   32'(g0), 32'd1);
      tick();
    end
    check("t5_count_after_gs", 32'(c0), 32'd3);
    mem_ready = 1'b1;
    #1;
    check("t5_r1_freeze", 32'(f0), 32'd1);
    check("t5_r1_bubble", 32'(b0), 32'd1);
    check("t5_r1_gstall", 32'(g0), 32'd0);
    tick();
    check("t5_r2_freeze", 32'(f0), 32'd1);
    tick();
    check("t5_r3_freeze", 32'(f0), 32'd0);
    check("t5_count", 32'(c0), 32'd5);

    // T6: branch flush beats raw; ex_slot is emptied
    do_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    tick();
    set_id(4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    branch_taken = 1'b1;
    #1;
    check("t6_br_freeze", 32'(f0), 32'd0);
    check("t6_br_bubble", 32'(b0), 32'd1);
    mem_ready = 1'b0;
    #1;
    check("t6_br_gs_freeze", 32'(f0), 32'd1);
    check("t6_br_gs_bubble", 32'(b0), 32'd0);
    mem_ready = 1'b1;
    #1;
    tick();
    branch_taken = 1'b0;
    set_id(4'd8, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    check("t6_ex_empty_freeze", 32'(f0), 32'd0);
    check("t6_count", 32'(c0), 32'd0);

    // Saturation on the 2-bit counter, then clear (clear wins over freeze)
    do_reset();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) tick();
    check("sat_c2", 32'(c2), 32'd3);
    check("sat_c0", 32'(c0), 32'd5);
    stall_count_clr = 1'b1;
    tick();
    stall_count_clr = 1'b0;
    check("clr_c2", 32'(c2), 32'd0);
    check("clr_c0", 32'(c0), 32'd0);

    // Reset mid-stall clears immediately; first cycle after release is clean
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_freeze", 32'(f0), 32'd0);
    check("rst_mid_count",  32'(c0), 32'd0);
    mem_ready = 1'b1;
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_rel_freeze", 32'(f0), 32'd0);
    tick();
    check("rst_rel_count", 32'(c0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
